// File: rtl/adc_ramp_checker.sv
// Checks a multi-channel ADC test ramp ({id, ramp} per 16-bit lane), locks onto it and
// reports per-beat errors, a saturating error count and sticky per-channel mismatch flags.
module adc_ramp_checker #(
    parameter int NUM_CH     = 4,
    parameter int CH_ID_BASE = 0,
    parameter int LOCK_CNT   = 8,
    parameter int LOSS_CNT   = 4
) (
    input  logic                  device_clk,
    input  logic                  device_rst,
    input  logic                  adc_valid,
    input  logic [16*NUM_CH-1:0]  adc_data,
    input  logic                  clear_errors,
    output logic                  locked,
    output logic [1:0]            state,
    output logic                  error,
    output logic [15:0]           error_count,
    output logic [NUM_CH-1:0]     ch_error_mask
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'b00,
        ST_ACQUIRE = 2'b01,
        ST_LOCKED  = 2'b10
    } state_t;

    localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_TGT = 8'(LOSS_CNT);

    state_t              r_state;
    logic [7:0]          r_exp_ramp;
    logic [7:0]          r_match_cnt;
    logic [7:0]          r_bad_cnt;
    logic                r_locked;
    logic                r_error;
    logic [15:0]         r_error_count;
    logic [NUM_CH-1:0]   r_ch_error_mask;

    logic [7:0]          w_ramp0;
    logic [7:0]          w_ramp0_inc;
    logic [7:0]          w_match_inc;
    logic [7:0]          w_bad_inc;
    logic [NUM_CH-1:0]   w_id_ok;
    logic [NUM_CH-1:0]   w_ramp_eq0;
    logic [NUM_CH-1:0]   w_ch_mismatch;
    logic                w_self_cons;
    logic                w_good;

    assign w_ramp0     = adc_data[7:0];
    assign w_ramp0_inc = w_ramp0 + 8'd1;
    assign w_match_inc = r_match_cnt + 8'd1;
    assign w_bad_inc   = r_bad_cnt + 8'd1;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [7:0] EXP_ID = 8'((CH_ID_BASE + gi) % 256);
            assign w_id_ok[gi]       = (adc_data[16*gi+8 +: 8] == EXP_ID);
            assign w_ramp_eq0[gi]    = (adc_data[16*gi +: 8] == w_ramp0);
            // Mismatch is judged against the freewheeling expectation, not channel 0.
            assign w_ch_mismatch[gi] = !w_id_ok[gi] || (adc_data[16*gi +: 8] != r_exp_ramp);
        end
    endgenerate

    assign w_self_cons = (&w_id_ok) && (&w_ramp_eq0);
    assign w_good      = w_self_cons && (w_ramp0 == r_exp_ramp);

    always_ff @(posedge device_clk) begin
        if (device_rst) begin
            r_state         <= ST_SEARCH;
            r_exp_ramp      <= 8'd0;
            r_match_cnt     <= 8'd0;
            r_bad_cnt       <= 8'd0;
            r_locked        <= 1'b0;
            r_error         <= 1'b0;
            r_error_count   <= 16'd0;
            r_ch_error_mask <= '0;
        end else begin
            r_error <= 1'b0;
            if (adc_valid) begin
                case (r_state)
                    ST_SEARCH, ST_ACQUIRE: begin
                        r_exp_ramp <= w_ramp0_inc;
                        if (r_state == ST_ACQUIRE && w_good) begin
                            r_match_cnt <= w_match_inc;
                            if (w_match_inc == LOCK_TGT) begin
                                r_state   <= ST_LOCKED;
                                r_locked  <= 1'b1;
                                r_bad_cnt <= 8'd0;
                            end
                        end else if (w_self_cons) begin
                            // Bad ACQUIRE beats fall through here and reseed like SEARCH.
                            r_match_cnt <= 8'd1;
                            r_state     <= ST_ACQUIRE;
                        end else begin
                            r_match_cnt <= 8'd0;
                            r_state     <= ST_SEARCH;
                        end
                    end
                    ST_LOCKED: begin
                        r_exp_ramp <= r_exp_ramp + 8'd1;
                        if (w_good) begin
                            r_bad_cnt <= 8'd0;
                        end else begin
                            r_error         <= 1'b1;
                            r_ch_error_mask <= r_ch_error_mask | w_ch_mismatch;
                            if (r_error_count != 16'hFFFF)
                                r_error_count <= r_error_count + 16'd1;
                            if (w_bad_inc == LOSS_TGT) begin
                                r_state     <= ST_SEARCH;
                                r_locked    <= 1'b0;
                                r_bad_cnt   <= 8'd0;
                                r_match_cnt <= 8'd0;
                            end else begin
                                r_bad_cnt <= w_bad_inc;
                            end
                        end
                    end
                    default: begin
                        r_state  <= ST_SEARCH;
                        r_locked <= 1'b0;
                    end
                endcase
            end
            if (clear_errors) begin
                r_error_count   <= 16'd0;
                r_ch_error_mask <= '0;
            end
        end
    end

    assign locked        = r_locked;
    assign state         = r_state;
    assign error         = r_error;
    assign error_count   = r_error_count;
    assign ch_error_mask = r_ch_error_mask;

endmodule

// File: tb/tb_adc_ramp_checker.sv
// Scoreboard bench for adc_ramp_checker: a driver feeds directed and random beats through a
// behavioural model into an expectation queue; a monitor compares the DUT after every edge.
module tb_adc_ramp_checker;

    localparam int NUM_CH   = 4;
    localparam int BASE     = 0;
    localparam int LOCK_CNT = 8;
    localparam int LOSS_CNT = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 valid;
    logic [16*NUM_CH-1:0] data;
    logic                 clr;
    logic                 locked;
    logic [1:0]           state;
    logic                 error;
    logic [15:0]          error_count;
    logic [NUM_CH-1:0]    ch_error_mask;

    adc_ramp_checker #(
        .NUM_CH(NUM_CH), .CH_ID_BASE(BASE), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)
    ) dut (
        .device_clk(clk), .device_rst(rst), .adc_valid(valid), .adc_data(data),
        .clear_errors(clr), .locked(locked), .state(state), .error(error),
        .error_count(error_count), .ch_error_mask(ch_error_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        st;
        logic              lk;
        logic              er;
        logic [15:0]       cnt;
        logic [NUM_CH-1:0] mask;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    // Reference model state: mode 0 search, 1 acquire, 2 locked
    int m_mode = 0, m_exp = 0, m_run = 0, m_bad = 0, m_cnt = 0, m_mask = 0, m_err = 0;

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (txn %0d)", name, act, req, txn);
        end
    endtask

    // kind: 0 clean, 1 ramp of channel ch corrupted, 2 id of channel ch corrupted
    task automatic beat(input bit v, input bit c, input bit r, input int ramp, input int kind,
                        input int ch);
        int   ids[NUM_CH];
        int   rmp[NUM_CH];
        bit   selfc, good;
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < NUM_CH; i++) begin
            ids[i] = (BASE + i) % 256;
            rmp[i] = ramp % 256;
        end
        if (kind == 1) rmp[ch] = rmp[ch] ^ 8'h55;
        if (kind == 2) ids[ch] = ids[ch] ^ 8'h01;
        for (int i = 0; i < NUM_CH; i++) data[16*i +: 16] = {8'(ids[i]), 8'(rmp[i])};
        valid = v; clr = c; rst = r;
        m_err = 0;
        if (r) begin
            m_mode = 0; m_exp = 0; m_run = 0; m_bad = 0; m_cnt = 0; m_mask = 0;
        end else begin
            if (v) begin
                selfc = 1;
                for (int i = 0; i < NUM_CH; i++)
                    if (ids[i] != (BASE + i) % 256 || rmp[i] != rmp[0]) selfc = 0;
                good = selfc && (rmp[0] == m_exp);
                if (m_mode == 2) begin
                    if (good) m_bad = 0;
                    else begin
                        m_err = 1;
                        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                        for (int i = 0; i < NUM_CH; i++)
                            if (ids[i] != (BASE + i) % 256 || rmp[i] != m_exp) m_mask |= (1 << i);
                        m_bad++;
                        if (m_bad == LOSS_CNT) begin m_mode = 0; m_bad = 0; end
                    end
                    m_exp = (m_exp + 1) % 256;
                end else begin
                    if (m_mode == 1 && good) begin
                        m_run++;
                        if (m_run == LOCK_CNT) begin m_mode = 2; m_bad = 0; end
                    end else if (selfc) begin
                        m_run = 1; m_mode = 1;
                    end else begin
                        m_run = 0; m_mode = 0;
                    end
                    m_exp = (rmp[0] + 1) % 256;
                end
            end
            if (c) begin m_cnt = 0; m_mask = 0; end
        end
        e.st = 2'(m_mode); e.lk = (m_mode == 2); e.er = 1'(m_err);
        e.cnt = 16'(m_cnt); e.mask = NUM_CH'(m_mask);
        q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk); #2;
    endtask

    task automatic spot(input string name, input int st, input int lk, input int er, input int cnt,
                        input int mask);
        cmp({name, ".state"}, int'(state), st);
        cmp({name, ".locked"}, int'(locked), lk);
        cmp({name, ".error"}, int'(error), er);
        cmp({name, ".count"}, int'(error_count), cnt);
        cmp({name, ".mask"}, int'(ch_error_mask), mask);
    endtask

    // Monitor: every edge is an output transaction of this block
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                txn++;
                cmp("sb.state", int'(state), int'(e.st));
                cmp("sb.locked", int'(locked), int'(e.lk));
                cmp("sb.error", int'(error), int'(e.er));
                cmp("sb.count", int'(error_count), int'(e.cnt));
                cmp("sb.mask", int'(ch_error_mask), int'(e.mask));
                $display("txn %0d: state=%0d locked=%0b error=%0b count=%0d mask=%b",
                         txn, state, locked, error, error_count, ch_error_mask);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int src, f, k, waited;
        rst = 1'b1; valid = 1'b0; clr = 1'b0; data = '0;
        beat(0, 0, 1, 0, 0, 0);
        beat(1, 1, 1, 9, 0, 0);
        settle(); spot("reset", 0, 0, 0, 0, 0);

        // Ramp from 0: acquire after the first beat, lock after the eighth
        src = 0;
        beat(1, 0, 0, src, 0, 0); src++;
        settle(); spot("acq_beat1", 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin beat(1, 0, 0, src, 0, 0); src++; end
        settle(); spot("lock_beat8", 2, 1, 0, 0, 0);

        // Wrap through 0xFF with valid alternating
        for (int i = 0; i < 560; i++) begin
            beat(i % 2 == 0, 0, 0, src, 0, 0);
            if (i % 2 == 0) src++;
        end
        settle(); spot("wrap", 2, 1, 0, 0, 0);

        // One corrupted beat on channel 2
        beat(1, 0, 0, src, 1, 2); src++;
        settle(); spot("ch2_bad", 2, 1, 1, 1, 4'b0100);
        beat(1, 0, 0, src, 0, 0); src++;
        settle(); spot("ch2_after", 2, 1, 0, 1, 4'b0100);

        // Frozen ramp: four bad beats drop lock, then relock after eight good beats
        beat(0, 1, 0, 0, 0, 0);
        f = src - 1;
        for (int i = 0; i < 4; i++) beat(1, 0, 0, f, 0, 0);
        settle(); spot("frozen_loss", 0, 0, 1, 4, 4'b1111);
        src = f + 1;
        for (int i = 0; i < 7; i++) begin beat(1, 0, 0, src, 0, 0); src++; end
        settle(); spot("relock7", 1, 0, 0, 4, 4'b1111);
        beat(1, 0, 0, src, 0, 0); src++;
        settle(); spot("relock8", 2, 1, 0, 4, 4'b1111);

        // Clear on the same cycle as a bad locked beat
        beat(1, 1, 0, src, 2, 1); src++;
        settle(); spot("clr_bad", 2, 1, 1, 0, 0);

        // Reset while locked, with a valid beat on the bus
        beat(1, 0, 1, src, 0, 0);
        settle(); spot("rst_locked", 0, 0, 0, 0, 0);

        // Jump 0x20 -> 0x80 at match count 5
        for (int r = 'h1C; r <= 'h20; r++) beat(1, 0, 0, r, 0, 0);
        beat(1, 0, 0, 'h80, 0, 0);
        settle(); spot("jump", 1, 0, 0, 0, 0);
        for (int r = 'h81; r <= 'h86; r++) beat(1, 0, 0, r, 0, 0);
        settle(); spot("jump_6", 1, 0, 0, 0, 0);
        beat(1, 0, 0, 'h87, 0, 0);
        settle(); spot("jump_7", 2, 1, 0, 0, 0);

        // Random traffic
        src = 'h88;
        for (int i = 0; i < 2000; i++) begin
            k = $urandom_range(0, 99);
            if (k < 4)       beat(1, 0, 0, src, 1, $urandom_range(0, NUM_CH - 1));
            else if (k < 7)  beat(1, 0, 0, src, 2, $urandom_range(0, NUM_CH - 1));
            else if (k < 10) beat(1, 0, 0, src - 1, 0, 0);
            else if (k < 12) begin src = $urandom_range(0, 255); beat(1, 0, 0, src, 0, 0); end
            else if (k < 13) beat($urandom_range(0, 1), 0, 1, src, 0, 0);
            else if (k < 16) beat($urandom_range(0, 1), 1, 0, src, 0, 0);
            else if (k < 35) beat(0, 0, 0, $urandom_range(0, 255), 0, 0);
            else             beat(1, 0, 0, src, 0, 0);
            if (valid && k >= 10) src = (src + 1) % 256;
        end

        waited = 0;
        while (q.size() > 0 && waited < 10) begin @(posedge clk); waited++; end
        #3;
        cmp("drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_ramp_checker.md
ADC_RAMP_CHECKER -- requirements
Module: adc_ramp_checker

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of 16-bit sample channels checked in parallel (1..32).
REQ-002 SHALL have parameter CH_ID_BASE, default 0, expected channel ID of channel 0; channel c expects (CH_ID_BASE+c) mod 256.
REQ-003 SHALL have parameter LOCK_CNT, default 8, consecutive good beats required to lock (2..255).
REQ-004 SHALL have parameter LOSS_CNT, default 4, consecutive bad beats that drop lock (1..255).
REQ-005 SHALL have port device_clk  input  1  the only clock; all logic is on its rising edge.
REQ-006 SHALL have port device_rst  input  1  reset, synchronous to device_clk and active-high.
REQ-007 SHALL have port adc_valid  input  1  qualifies adc_data for the current cycle.
REQ-008 SHALL have port adc_data  input  16*NUM_CH  channel c occupies bits [16c+15:16c], format {id[7:0], ramp[7:0]}.
REQ-009 SHALL have port clear_errors  input  1  single-cycle request to zero error statistics.
REQ-010 SHALL have port locked  output  1  high while in state LOCKED.
REQ-011 SHALL have port state  output  2  00 SEARCH, 01 ACQUIRE, 10 LOCKED.
REQ-012 SHALL have port error  output  1  one-cycle pulse per bad beat while LOCKED.
REQ-013 SHALL have port error_count  output  16  saturating count of bad beats while LOCKED.
REQ-014 SHALL have port ch_error_mask  output  NUM_CH  sticky per-channel mismatch flags while LOCKED.

Function
REQ-015 SHALL define a beat as a cycle with adc_valid=1; all state, counters and the expected ramp SHALL hold on cycles with adc_valid=0.
REQ-016 SHALL define a beat self-consistent when every channel id equals its expected ID and every channel ramp equals channel 0 ramp.
REQ-017 SHALL define a beat good when it is self-consistent and channel 0 ramp equals exp_ramp; channel c mismatches when its id or ramp differs from its expected value.
REQ-018 SHALL update exp_ramp to (accepted ramp + 1) mod 256 on every beat in SEARCH/ACQUIRE, and to exp_ramp+1 on every beat in LOCKED (freewheel; 255 wraps to 0).
REQ-019 SEARCH: a self-consistent beat SHALL seed exp_ramp, set match_cnt=1 and move to ACQUIRE; other beats SHALL stay in SEARCH.
REQ-020 ACQUIRE: a good beat SHALL increment match_cnt; when it reaches LOCK_CNT the state SHALL become LOCKED.
REQ-021 ACQUIRE: a bad beat SHALL be re-evaluated as a SEARCH beat in the same cycle (reseed, match_cnt=1, stay ACQUIRE if self-consistent, else go to SEARCH).
REQ-022 LOCKED: a good beat SHALL clear the consecutive-bad counter; a bad beat SHALL increment it, and on reaching LOSS_CNT the state SHALL become SEARCH.
REQ-023 LOCKED bad beat SHALL pulse error, increment error_count (saturate at 0xFFFF) and OR mismatching channels into ch_error_mask.
REQ-024 All outputs SHALL be registered; effects of a beat sampled at edge N SHALL be visible after edge N (one-cycle latency).
REQ-025 clear_errors SHALL zero error_count and ch_error_mask and SHALL take priority over a simultaneous increment; the error pulse SHALL still fire.
REQ-026 Leaving LOCKED SHALL NOT clear error_count or ch_error_mask.

Reset
REQ-027 device_rst=1 at a clock edge SHALL force state=SEARCH, locked=0, error=0, error_count=0, ch_error_mask=0, match_cnt=0, bad counter=0, exp_ramp=0.
REQ-028 device_rst SHALL override all other inputs, including mid-ACQUIRE or mid-LOCKED, and the first beat after release SHALL be treated as a SEARCH beat.

Verification
REQ-029 Ramp 0x00.. on all channels with id=c, valid every cycle -> ACQUIRE after beat 1, locked=1 after beat 8, error_count stays 0.
REQ-030 Locked stream wraps 0xFF->0x00 with valid toggling 1/0 -> no error, locked stays 1.
REQ-031 Locked, channel 2 ramp corrupted on one beat -> one error pulse, error_count=1, ch_error_mask=4'b0100, locked stays 1.
REQ-032 Locked, 4 consecutive beats with ramp frozen -> error_count=4, state=SEARCH after the 4th, relock after 8 further good beats, error_count still 4.
REQ-033 ACQUIRE at match_cnt=5, ramp jumps 0x20->0x80 -> match_cnt=1, state ACQUIRE, lock after 7 more good beats.
REQ-034 clear_errors on the same cycle as a bad locked beat -> error=1, error_count=0, ch_error_mask=0; device_rst while LOCKED -> all outputs at REQ-027 values next cycle.
